mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Iterative RV32M multiply/divide unit for the core's M-extension path.
//  Takes operands from register-file read ports RD1/RD2 and returns result + destination to the
//  write port (WD3/A3/WE3). Shift-add multiply and restoring divide, 1 bit/cycle; start/busy/done handshake.
// PARAMETERS
//  XLEN   32               operand/result width; only 32 supported
//  CNT_W  $clog2(XLEN)+1   iteration counter width (derived, do not override)
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     synchronous, active-low reset
//  start    in   1     request; sampled only in IDLE
//  funct3   in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_val  in   XLEN  operand A (from RD1)
//  rs2_val  in   XLEN  operand B (from RD2)
//  rd_addr  in   5     destination register
//  busy     out  1     high while state != IDLE
//  done     out  1     1-cycle pulse, result valid
//  result   out  XLEN  result (to WD3)
//  wb_addr  out  5     registered rd_addr (to A3)
//  wb_we    out  1     write enable (to WE3); pulses with done
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-low (rst=0 sampled at posedge). Outputs reset to 0:
//    busy, done, wb_we, result, wb_addr. FSM -> IDLE, counter -> 0.
//  - FSM: IDLE -(start)-> CALC -(count==0)-> DONE -> IDLE. No other transitions.
//  - Accept at edge N (IDLE, start=1): latch funct3, rd_addr, |A|, |B|, sign flags; counter=XLEN-1.
//  - CALC: exactly XLEN cycles, one bit/cycle; counter decrements and hits 0 on last iteration.
//  - DONE (cycle N+XLEN+1 after accept): done=1, wb_we=(wb_addr!=0); result/wb_addr valid.
//    busy high N+1..N+XLEN+1 inclusive. Next start sampled in cycle following DONE.
//  - start while busy: ignored, no queuing. Operand changes after accept: no effect.
//  - result and wb_addr hold after DONE until next DONE or reset; done/wb_we low outside DONE.
//  - Multiply: unsigned 2*XLEN product of magnitudes. Negate when sign(A)^sign(B) for signed
//    operands (MULH: both; MULHSU: A only; MUL: low half, sign-insensitive; MULHU: none).
//    MUL returns [XLEN-1:0]; MULH* return [2*XLEN-1:XLEN].
//  - Divide: restoring, unsigned on magnitudes. Quotient negated if sign(A)^sign(B) (DIV);
//    remainder takes sign of A (REM).
//  - B==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A. Forced regardless of signs.
//  - Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
//  - rd_addr==0: done pulses, wb_we stays 0 (register file has no x0 guard).
//  - rst=0 mid-operation: next edge returns to IDLE; no done/wb_we for aborted op.
// CONFIGURATION
//  MDU_EARLY_OUT_EN defined: B==0 on DIV/DIVU/REM/REMU, DIV/REM overflow case, or A==0 or B==0
//  on any MUL*: IDLE goes straight to DONE. done asserts in cycle N+1, busy high for only that
//  cycle, result per rules above.
//  MDU_EARLY_OUT_EN undefined: every op takes full XLEN CALC cycles (done at N+XLEN+1);
//  special-case results still forced in DONE.
// TESTING
//  1 MUL A=7,B=0xFFFFFFFD(-3),rd=5 -> done at N+33, result 0xFFFFFFEB, wb_addr 5, wb_we 1
//  2 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF
//  3 DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2
//  4 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0;
//    with MDU_EARLY_OUT_EN: done at N+1; without: done at N+33
//  5 rst=0 in 10th CALC cycle -> next cycle busy=0, done/wb_we never pulse; clean restart afterwards
//  6 start held high through op -> second op accepted only after DONE; rd=0 -> done=1, wb_we=0

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, 1 bit/cycle.
// Define MDU_EARLY_OUT_EN to skip CALC for zero-operand and forced-result cases.
module mdu_iterative #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       fn;
  logic             sa, sb, bz, ovf, mz;
  logic [XLEN-1:0]  a_raw, mb, lo;
  logic [XLEN:0]    hi;
  logic [4:0]       rd_q;

  logic            is_div_in, sa_in, sb_in;
  logic            bz_in, ovf_in, mz_in, early_in;
  logic [XLEN-1:0] abs_a_in, abs_b_in;

  assign is_div_in = funct3[2];
  assign sa_in = rs1_val[XLEN-1] &
    ((funct3 == 3'b001) | (funct3 == 3'b010) |
     (funct3 == 3'b100) | (funct3 == 3'b110));
  assign sb_in = rs2_val[XLEN-1] &
    ((funct3 == 3'b001) | (funct3 == 3'b100) |
     (funct3 == 3'b110));
  assign abs_a_in = sa_in ? -rs1_val : rs1_val;
  assign abs_b_in = sb_in ? -rs2_val : rs2_val;
  assign bz_in = (rs2_val == '0);
  assign ovf_in = is_div_in & ~funct3[0] &
    (rs1_val == MIN_NEG) & (rs2_val == '1);
  assign mz_in = ~is_div_in & ((rs1_val == '0) | bz_in);

`ifdef MDU_EARLY_OUT_EN
  assign early_in = is_div_in ? (bz_in | ovf_in) : mz_in;
`else
  assign early_in = 1'b0;
`endif

  // One iteration of each datapath; hi[XLEN] carries the mul sum
  logic [XLEN:0]   sum, sh, mul_hi, div_hi, hi_n;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] mul_lo, div_lo, lo_n;

  assign sum    = {1'b0, hi[XLEN-1:0]} +
                  (lo[0] ? {1'b0, mb} : '0);
  assign mul_hi = {1'b0, sum[XLEN:1]};
  assign mul_lo = {sum[0], lo[XLEN-1:1]};
  assign sh     = {hi[XLEN-1:0], lo[XLEN-1]};
  assign diff   = {1'b0, sh} - {2'b00, mb};
  assign div_hi = diff[XLEN+1] ? sh : diff[XLEN:0];
  assign div_lo = {lo[XLEN-2:0], ~diff[XLEN+1]};
  assign hi_n   = fn[2] ? div_hi : mul_hi;
  assign lo_n   = fn[2] ? div_lo : mul_lo;

  function automatic logic [XLEN-1:0] finalize(
    input logic [2:0]      f,
    input logic            fa,
    input logic            fb,
    input logic            fbz,
    input logic            fovf,
    input logic            fmz,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] h,
    input logic [XLEN-1:0] l
  );
    logic [2*XLEN-1:0] pm;
    logic [XLEN-1:0]   q, r, res;
    pm  = (fa ^ fb) ? -{h, l} : {h, l};
    q   = (fa ^ fb) ? -l : l;
    r   = fa ? -h : h;
    res = '0;
    unique case (f)
      3'b000: res = fmz ? '0 : pm[XLEN-1:0];
      3'b001, 3'b010, 3'b011:
        res = fmz ? '0 : pm[2*XLEN-1:XLEN];
      3'b100, 3'b101:
        res = fbz ? '1 : (fovf ? MIN_NEG : q);
      default:
        res = fbz ? a : (fovf ? '0 : r);
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      fn      <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      bz      <= 1'b0;
      ovf     <= 1'b0;
      mz      <= 1'b0;
      a_raw   <= '0;
      mb      <= '0;
      hi      <= '0;
      lo      <= '0;
      rd_q    <= '0;
      result  <= '0;
      wb_addr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            fn    <= funct3;
            sa    <= sa_in;
            sb    <= sb_in;
            bz    <= bz_in;
            ovf   <= ovf_in;
            mz    <= mz_in;
            a_raw <= rs1_val;
            mb    <= abs_b_in;
            hi    <= '0;
            lo    <= abs_a_in;
            rd_q  <= rd_addr;
            cnt   <= CNT_W'(XLEN - 1);
            if (early_in) begin
              result  <= finalize(funct3, sa_in, sb_in,
                                  bz_in, ovf_in, mz_in,
                                  rs1_val, '0, '0);
              wb_addr <= rd_addr;
              state   <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result  <= finalize(fn, sa, sb, bz, ovf, mz,
                                a_raw, hi_n[XLEN-1:0], lo_n);
            wb_addr <= rd_q;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign wb_we = done & (wb_addr != '0);

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed RV32M vectors,
// monitor checks result/wb_addr/wb_we/latency on every done pulse.
module tb_mdu_iterative;

  localparam int XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam int EL = 0;
`else
  localparam int EL = XLEN;
`endif
  localparam int FL = XLEN;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic [4:0]      rd_addr = '0;
  logic            busy, done, wb_we;
  logic [XLEN-1:0] result;
  logic [4:0]      wb_addr;

  mdu_iterative dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wb_addr (wb_addr),
    .wb_we   (wb_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [4:0]      addr;
    logic            we;
    int              acc;
    int              lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vecs = 0;
  int   fails = 0;
  int   last_acc = 0;

  task automatic chk(input string n, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        vecs++;
        fails++;
        $display("FAIL unexpected_done: got result %h want no done",
                 result);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("wb_addr", 32'(wb_addr), 32'(e.addr));
        chk("wb_we", 32'(wb_we), 32'(e.we));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] rd,
                       input logic [XLEN-1:0] er, input int el,
                       input bit push, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      vecs++;
      fails++;
      $display("FAIL issue_wait: got busy=1 want busy=0");
    end
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    rd_addr = rd;
    start   = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!hold) start = 1'b0;
    if (push) q.push_back('{er, rd, rd != 5'd0, last_acc, el});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    rst = 1'b1;

    issue(MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, FL, 1, 0);
    issue(MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, FL, 1, 0);
    issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, FL, 1, 0);
    issue(MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, FL, 1, 0);
    issue(DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, FL, 1, 0);
    issue(REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, FL, 1, 0);
    issue(DIVU,   32'd100,      32'd7,        5'd11, 32'd14,       FL, 1, 0);
    issue(REMU,   32'd100,      32'd7,        5'd12, 32'd2,        FL, 1, 0);
    issue(DIVU,   32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, EL, 1, 0);
    issue(REM,    32'd5,        32'd0,        5'd14, 32'd5,        EL, 1, 0);
    issue(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, EL, 1, 0);
    issue(REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        EL, 1, 0);
    issue(DIV,    32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFFF, EL, 1, 0);
    issue(REM,    32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFF9, EL, 1, 0);
    issue(MUL,    32'h12345678, 32'd0,        5'd19, 32'd0,        EL, 1, 0);
    issue(MULHU,  32'd0,        32'hFFFFFFFF, 5'd20, 32'd0,        EL, 1, 0);

    // Abort in the 10th CALC cycle; the op must never complete
    issue(MUL, 32'd3, 32'd4, 5'd7, 32'd12, FL, 0, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (40) @(posedge clk);

    issue(MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, FL, 1, 0);

    // start held high; operands swapped after accept, rd=0 suppresses write
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFE, FL, 1, 1);
    funct3  = DIVU;
    rs1_val = 32'd100;
    rs2_val = 32'd7;
    rd_addr = 5'd9;
    q.push_back('{32'd14, 5'd9, 1'b1, last_acc + XLEN + 2, FL});
    repeat (XLEN + 2) @(posedge clk);
    #1 start = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vecs++;
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    repeat (3) @(negedge clk);
    chk("hold_result", result, 32'd14);
    chk("hold_wb_addr", 32'(wb_addr), 32'd9);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_we", 32'(wb_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
